// File: rtl/ssm2603_adc_rx_if.sv
// ---------------------------------------------------------------------------
// ssm2603_adc_rx_if
//   Parallel sample hand-off between the SSM2603 ADC capture block and the
//   downstream DSP.
//
//   sample_l / sample_r : signed left/right samples of the last completed pair
//   sample_valid        : a pair is available; held until acknowledged
//   sample_ack          : consumer accepts the current pair
//   overrun             : sticky, a pair was overwritten before it was acked
//   overrun_clr         : clears overrun
//
//   master : the capture block (produces samples)
//   slave  : the consumer (acks samples, clears overrun)
// ---------------------------------------------------------------------------
interface ssm2603_adc_rx_if #(
    parameter int SAMPLE_BITS = 24
);
    logic [SAMPLE_BITS-1:0] sample_l;
    logic [SAMPLE_BITS-1:0] sample_r;
    logic                   sample_valid;
    logic                   sample_ack;
    logic                   overrun;
    logic                   overrun_clr;

    modport master (
        output sample_l,
        output sample_r,
        output sample_valid,
        output overrun,
        input  sample_ack,
        input  overrun_clr
    );

    modport slave (
        input  sample_l,
        input  sample_r,
        input  sample_valid,
        input  overrun,
        output sample_ack,
        output overrun_clr
    );
endinterface

// File: rtl/ssm2603_adc_rx.sv
// ---------------------------------------------------------------------------
// ssm2603_adc_rx
//   Capture side of the SSM2603 codec audio interface. Acts as LRCK master for
//   the ADC path, deserializes I2S-format AUD_ADCDAT into left/right samples
//   and hands each completed stereo pair to the consumer with a valid/ack
//   handshake and a sticky overrun flag. Everything runs on AUD_BCLK.
//
//   Ports:
//     AUD_BCLK    : bit clock, sole clock, rising edge
//     rst_n       : asynchronous active-low reset
//     enable      : 1 = run framing/capture, 0 = hold idle
//     AUD_ADCDAT  : serial ADC data from the codec (changes on falling edge)
//     AUD_ADCLRCK : channel select to the codec, 0 = left, 1 = right
//     bus         : sample hand-off (see ssm2603_adc_rx_if), master side
//
//   Parameters:
//     FRAME_CLKS  : BCLK cycles per LR pair, even
//     SAMPLE_BITS : bits captured per channel, 1 .. FRAME_CLKS/2-1
// ---------------------------------------------------------------------------
module ssm2603_adc_rx #(
    parameter int FRAME_CLKS  = 96,
    parameter int SAMPLE_BITS = 24
) (
    input  logic              AUD_BCLK,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              AUD_ADCDAT,
    output logic              AUD_ADCLRCK,
    ssm2603_adc_rx_if.master  bus
);

    localparam int HALF = FRAME_CLKS / 2;
    localparam int CW   = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;

    typedef logic [CW-1:0]          cnt_t;
    typedef logic [SAMPLE_BITS-1:0] word_t;

    // Counter positions of interest (values of c before the edge).
    localparam cnt_t C_LAST    = cnt_t'(FRAME_CLKS - 1);
    localparam cnt_t C_HALF    = cnt_t'(HALF);
    localparam cnt_t C_L_FIRST = cnt_t'(1);
    localparam cnt_t C_L_LAST  = cnt_t'(SAMPLE_BITS);
    localparam cnt_t C_R_FIRST = cnt_t'(HALF + 1);
    localparam cnt_t C_R_LAST  = cnt_t'(HALF + SAMPLE_BITS);

    // Framing / capture state
    cnt_t  c;
    logic  lrck_q;
    word_t shift_l;
    word_t shift_r;
    word_t hold_l;

    // Output state
    word_t sample_l_q;
    word_t sample_r_q;
    logic  valid_q;
    logic  overrun_q;

    // Combinational helpers
    cnt_t  c_next;
    logic  in_left;
    logic  in_right;
    logic  left_done;
    logic  pair_done;
    logic  overrun_set;
    word_t shift_l_in;
    word_t shift_r_in;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path can leave it unassigned, which would infer a latch.
    always_comb begin
        c_next      = (c == C_LAST) ? '0 : c + cnt_t'(1);
        in_left     = 1'b0;
        in_right    = 1'b0;
        left_done   = 1'b0;
        pair_done   = 1'b0;
        overrun_set = 1'b0;
        // MSB arrives first, so each new bit enters on the LSB side.
        shift_l_in  = (shift_l << 1) | word_t'(AUD_ADCDAT);
        shift_r_in  = (shift_r << 1) | word_t'(AUD_ADCDAT);

        if (enable) begin
            // I2S: data starts one BCLK after the LRCK transition.
            in_left   = (c >= C_L_FIRST) && (c <= C_L_LAST);
            in_right  = (c >= C_R_FIRST) && (c <= C_R_LAST);
            left_done = (c == C_L_LAST);
            pair_done = (c == C_R_LAST);
        end

        // A pair lands on top of an unacknowledged one. An ack on the same
        // edge hands the old pair over in time, so that is not an overrun.
        overrun_set = pair_done && valid_q && !bus.sample_ack;
    end

    // Framing and deserialization. Leaving enable low parks the frame at
    // c = 0 and discards any partially captured pair.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge AUD_BCLK or negedge rst_n) begin
        if (!rst_n) begin
            c       <= '0;
            lrck_q  <= 1'b0;
            shift_l <= '0;
            shift_r <= '0;
            hold_l  <= '0;
        end else if (!enable) begin
            c       <= '0;
            lrck_q  <= 1'b0;
            shift_l <= '0;
            shift_r <= '0;
            hold_l  <= '0;
        end else begin
            c <= c_next;
            // LRCK is registered from the next count so it moves on the same
            // edge as c and never glitches.
            lrck_q <= (c_next >= C_HALF);
            if (in_left) begin
                shift_l <= shift_l_in;
            end
            if (in_right) begin
                shift_r <= shift_r_in;
            end
            // Park the left word until the right one completes so both
            // outputs of a pair change together.
            if (left_done) begin
                hold_l <= shift_l_in;
            end
        end
    end

    // Sample hand-off. Keeps running while enable is low so the consumer can
    // still drain the last pair and clear overrun.
    always_ff @(posedge AUD_BCLK or negedge rst_n) begin
        if (!rst_n) begin
            sample_l_q <= '0;
            sample_r_q <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (pair_done) begin
                sample_l_q <= hold_l;
                sample_r_q <= shift_r_in;
                valid_q    <= 1'b1;
            end else if (bus.sample_ack) begin
                valid_q    <= 1'b0;
            end

            // Set wins over clear.
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (bus.overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign AUD_ADCLRCK      = lrck_q;
    assign bus.sample_l     = sample_l_q;
    assign bus.sample_r     = sample_r_q;
    assign bus.sample_valid = valid_q;
    assign bus.overrun      = overrun_q;

endmodule
